// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: examines CHUNK bits per clock, MSB first,
// and finishes at the first differing chunk. Unsigned or two's-complement.
module serial_magnitude_comparator #(
    parameter  int WIDTH  = 16,
    parameter  int CHUNK  = 4,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_gt_B,
    output logic             A_lt_B,
    output logic             A_eq_B,
    output logic [IDXW:0]    chunks_used,
    output logic [0:0]       o_state
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CMP  = 1'b1;

    // Handshake: start is sampled only while busy=0 (IDLE); a start seen in
    // CMP is dropped. done pulses for one cycle when the flags update, and
    // the machine is already IDLE in that cycle, so start may be asserted then.

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDXW-1:0]  r_idx;
    logic             r_done;
    logic             r_gt;
    logic             r_lt;
    logic             r_eq;
    logic [IDXW:0]    r_chunks;

    logic [CHUNK-1:0] w_a_top;
    logic [CHUNK-1:0] w_b_top;
    logic             w_last;

    assign w_a_top = r_a[WIDTH-1 -: CHUNK];
    assign w_b_top = r_b[WIDTH-1 -: CHUNK];
    assign w_last  = (r_idx == IDXW'(NCHUNK - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_done   <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
            r_chunks <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Flipping the sign bit maps two's complement onto
                        // offset binary, so the unsigned chunk compare holds.
                        if (signed_mode) begin
                            r_a <= {~A[WIDTH-1], A[WIDTH-2:0]};
                            r_b <= {~B[WIDTH-1], B[WIDTH-2:0]};
                        end else begin
                            r_a <= A;
                            r_b <= B;
                        end
                        r_idx   <= '0;
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (w_a_top != w_b_top) begin
                        r_gt     <= (w_a_top > w_b_top);
                        r_lt     <= (w_a_top < w_b_top);
                        r_eq     <= 1'b0;
                        r_chunks <= {1'b0, r_idx} + (IDXW + 1)'(1);
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end else if (w_last) begin
                        r_gt     <= 1'b0;
                        r_lt     <= 1'b0;
                        r_eq     <= 1'b1;
                        r_chunks <= (IDXW + 1)'(NCHUNK);
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_a   <= r_a << CHUNK;
                        r_b   <= r_b << CHUNK;
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state == S_CMP);
    assign done        = r_done;
    assign A_gt_B      = r_gt;
    assign A_lt_B      = r_lt;
    assign A_eq_B      = r_eq;
    assign chunks_used = r_chunks;
    assign o_state     = r_state;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: three chunk sizes side by side,
// a cycle-level reference model plus directed scenarios with literal results.
module tb_serial_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    always #5 clk = ~clk;

    int ch[3] = '{4, 1, 16};

    logic       busy_c4, done_c4, gt_c4, lt_c4, eq_c4;
    logic [2:0] cu_c4;
    logic [0:0] st_c4;
    logic       busy_c1, done_c1, gt_c1, lt_c1, eq_c1;
    logic [4:0] cu_c1;
    logic [0:0] st_c1;
    logic       busy_c16, done_c16, gt_c16, lt_c16, eq_c16;
    logic [1:0] cu_c16;
    logic [0:0] st_c16;

    serial_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .A(a), .B(b), .busy(busy_c4), .done(done_c4), .A_gt_B(gt_c4),
        .A_lt_B(lt_c4), .A_eq_B(eq_c4), .chunks_used(cu_c4), .o_state(st_c4));

    serial_magnitude_comparator #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .A(a), .B(b), .busy(busy_c1), .done(done_c1), .A_gt_B(gt_c1),
        .A_lt_B(lt_c1), .A_eq_B(eq_c1), .chunks_used(cu_c1), .o_state(st_c1));

    serial_magnitude_comparator #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .A(a), .B(b), .busy(busy_c16), .done(done_c16), .A_gt_B(gt_c16),
        .A_lt_B(lt_c16), .A_eq_B(eq_c16), .chunks_used(cu_c16), .o_state(st_c16));

    logic act_busy[3], act_done[3], act_gt[3], act_lt[3], act_eq[3];
    int   act_cu[3];

    always_comb begin
        act_busy[0] = busy_c4;  act_done[0] = done_c4;  act_gt[0] = gt_c4;
        act_lt[0]   = lt_c4;    act_eq[0]   = eq_c4;    act_cu[0] = int'(cu_c4);
        act_busy[1] = busy_c1;  act_done[1] = done_c1;  act_gt[1] = gt_c1;
        act_lt[1]   = lt_c1;    act_eq[1]   = eq_c1;    act_cu[1] = int'(cu_c1);
        act_busy[2] = busy_c16; act_done[2] = done_c16; act_gt[2] = gt_c16;
        act_lt[2]   = lt_c16;   act_eq[2]   = eq_c16;   act_cu[2] = int'(cu_c16);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Index of the chunk holding the most significant differing bit; flipping
    // both sign bits leaves A^B unchanged, so this holds in signed mode too.
    function automatic int first_diff(input logic [15:0] x, input logic [15:0] y, input int c);
        logic [15:0] d;
        d = x ^ y;
        if (d == 16'h0) return 16 / c - 1;
        for (int p = 15; p >= 0; p--)
            if (d[p]) return (15 - p) / c;
        return 0;
    endfunction

    bit m_busy[3], m_done[3], m_gt[3], m_lt[3], m_eq[3];
    bit p_gt[3], p_lt[3], p_eq[3];
    int m_cnt[3], m_cu[3], p_cu[3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_busy[k] = 0; m_done[k] = 0; m_gt[k] = 0; m_lt[k] = 0;
                m_eq[k] = 0; m_cnt[k] = 0; m_cu[k] = 0;
            end else begin
                m_done[k] = 0;
                if (m_busy[k]) begin
                    m_cnt[k]--;
                    if (m_cnt[k] == 0) begin
                        m_busy[k] = 0; m_done[k] = 1;
                        m_gt[k] = p_gt[k]; m_lt[k] = p_lt[k];
                        m_eq[k] = p_eq[k]; m_cu[k] = p_cu[k];
                    end
                end else if (start) begin
                    int jj;
                    jj = first_diff(a, b, ch[k]);
                    if (signed_mode) begin
                        p_gt[k] = $signed(a) > $signed(b);
                        p_lt[k] = $signed(a) < $signed(b);
                    end else begin
                        p_gt[k] = a > b;
                        p_lt[k] = a < b;
                    end
                    p_eq[k] = (a == b);
                    p_cu[k] = jj + 1;
                    m_cnt[k] = jj + 1;
                    m_busy[k] = 1;
                end
            end
        end
    end

    bit chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("c%0d_busy", ch[k]), int'(act_busy[k]), int'(m_busy[k]));
                chk($sformatf("c%0d_done", ch[k]), int'(act_done[k]), int'(m_done[k]));
                chk($sformatf("c%0d_gt", ch[k]), int'(act_gt[k]), int'(m_gt[k]));
                chk($sformatf("c%0d_lt", ch[k]), int'(act_lt[k]), int'(m_lt[k]));
                chk($sformatf("c%0d_eq", ch[k]), int'(act_eq[k]), int'(m_eq[k]));
                chk($sformatf("c%0d_chunks", ch[k]), act_cu[k], m_cu[k]);
            end
        end
    end

    int lat[3];
    int busy_cnt;

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy_c4 || busy_c1 || busy_c16) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy_c4 || busy_c1 || busy_c16) chk("idle_timeout", 1, 0);
    endtask

    // Starts one comparison and records per-instance latency in cycles.
    task automatic run(input logic [15:0] xa, input logic [15:0] xb, input logic s);
        @(negedge clk);
        a = xa; b = xb; signed_mode = s; start = 1'b1;
        for (int k = 0; k < 3; k++) lat[k] = -1;
        busy_cnt = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (busy_c4) busy_cnt++;
            for (int k = 0; k < 3; k++)
                if (act_done[k] && lat[k] < 0) lat[k] = cyc - 1;
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
        end
        for (int k = 0; k < 3; k++)
            if (lat[k] < 0) chk($sformatf("c%0d_done_seen", ch[k]), 0, 1);
    endtask

    initial begin
        int ndone;
        // Scenario 1: reset for two edges, release with start low
        @(negedge clk);
        @(negedge clk);
        chk_en = 1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_busy", int'(act_busy[k]), 0);
            chk("rst_done", int'(act_done[k]), 0);
            chk("rst_flags", int'({act_gt[k], act_lt[k], act_eq[k]}), 0);
            chk("rst_chunks", act_cu[k], 0);
        end

        // Scenario 2: MSB difference decides in the first chunk
        run(16'h8000, 16'h0000, 1'b0);
        chk("s2_lat_c4", lat[0], 1);
        chk("s2_flags_c4", int'({gt_c4, lt_c4, eq_c4}), 3'b100);
        chk("s2_cu_c4", int'(cu_c4), 1);
        chk("s2_lat_c1", lat[1], 1);
        chk("s2_cu_c1", int'(cu_c1), 1);
        chk("s2_lat_c16", lat[2], 1);
        chk("s2_gt_c16", int'(gt_c16), 1);
        wait_idle();

        // Scenario 3: equal operands run through every chunk
        run(16'h1234, 16'h1234, 1'b0);
        chk("s3_lat_c4", lat[0], 4);
        chk("s3_busy_c4", busy_cnt, 4);
        chk("s3_flags_c4", int'({gt_c4, lt_c4, eq_c4}), 3'b001);
        chk("s3_cu_c4", int'(cu_c4), 4);
        chk("s3_lat_c1", lat[1], 16);
        chk("s3_cu_c1", int'(cu_c1), 16);
        chk("s3_eq_c1", int'(eq_c1), 1);
        chk("s3_lat_c16", lat[2], 1);
        chk("s3_cu_c16", int'(cu_c16), 1);
        chk("s3_eq_c16", int'(eq_c16), 1);
        wait_idle();

        // Scenario 4: -1 vs 1 signed, then the same bits unsigned
        run(16'hFFFF, 16'h0001, 1'b1);
        chk("s4_signed_flags", int'({gt_c4, lt_c4, eq_c4}), 3'b010);
        chk("s4_signed_cu", int'(cu_c4), 1);
        wait_idle();
        run(16'hFFFF, 16'h0001, 1'b0);
        chk("s4_unsigned_flags", int'({gt_c4, lt_c4, eq_c4}), 3'b100);
        wait_idle();

        // Scenario 5: ignored mid-busy start, then back-to-back start in done cycle
        @(negedge clk);
        a = 16'h00A5; b = 16'h00A4; signed_mode = 1'b0; start = 1'b1;
        ndone = 0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (done_c4) ndone++;
            if (cyc == 1) start = 1'b0;
            if (cyc == 2) begin start = 1'b1; a = 16'h0001; b = 16'h0002; end
            if (cyc == 3) start = 1'b0;
        end
        chk("s5_done_in_cycle4", int'(done_c4), 1);
        chk("s5_done_count", ndone, 1);
        chk("s5_flags", int'({gt_c4, lt_c4, eq_c4}), 3'b100);
        chk("s5_cu", int'(cu_c4), 4);
        a = 16'h0000; b = 16'h0000; start = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
        end
        chk("s5_second_done", int'(done_c4), 1);
        chk("s5_second_flags", int'({gt_c4, lt_c4, eq_c4}), 3'b001);
        wait_idle();

        // Scenario 6: reset during CMP aborts silently
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("s6_busy", int'(busy_c4), 0);
        chk("s6_done", int'(done_c4), 0);
        chk("s6_flags", int'({gt_c4, lt_c4, eq_c4}), 0);
        chk("s6_cu", int'(cu_c4), 0);
        rst_n = 1'b1;
        run(16'h0010, 16'h0020, 1'b0);
        chk("s6_after_lat", lat[0], 3);
        chk("s6_after_flags", int'({gt_c4, lt_c4, eq_c4}), 3'b010);
        chk("s6_after_cu", int'(cu_c4), 3);
        chk("s6_after_cu_c1", int'(cu_c1), 11);
        wait_idle();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
